// File: rtl/div_sched.sv
// Round-robin request scheduler that sequences a shared fixed-latency divider
// and returns tagged results on one response channel; divide-by-zero bypasses the divider.
module div_sched #(
   parameter int NUM_REQ = 2,
   parameter int W       = 4,
   parameter int DIV_LAT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*W-1:0] req_dividend,
   input  logic [NUM_REQ*W-1:0] req_divisor,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_id,
   output logic [W-1:0]         rsp_quotient,
   output logic [W-1:0]         rsp_remainder,
   output logic                 rsp_dbz,
   output logic                 div_start,
   output logic [W-1:0]         div_dividend,
   output logic [W-1:0]         div_divisor,
   input  logic [W-1:0]         div_quotient,
   input  logic [W-1:0]         div_remainder,
   output logic                 busy
);

   localparam int unsigned NR = NUM_REQ;
   localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t state, state_nx;
   logic [1:0]     ptr, gidx, idx;
   logic           found;
   logic [3:0]     vld4;
   logic [4*W-1:0] dvd4, dvs4;
   logic [W-1:0]   sel_dvd, sel_dvs;
   logic [CW-1:0]  cnt;

   // Requester vectors are zero-padded to four entries so a 2-bit index is always in range.
   always_comb begin
      vld4 = '0;
      vld4[NUM_REQ-1:0] = req_valid;
      dvd4 = '0;
      dvd4[NUM_REQ*W-1:0] = req_dividend;
      dvs4 = '0;
      dvs4[NUM_REQ*W-1:0] = req_divisor;
      found = 1'b0;
      gidx  = '0;
      idx   = '0;
      if (state == S_IDLE && !rst) begin
         for (int unsigned i = 1; i <= NR; i++) begin
            idx = 2'((32'(ptr) + i) % NR);
            if (!found && vld4[idx]) begin
               found = 1'b1;
               gidx  = idx;
            end
         end
      end
      sel_dvd = dvd4[gidx*W +: W];
      sel_dvs = dvs4[gidx*W +: W];
   end

   assign req_ready = NUM_REQ'(found) << gidx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (found) state_nx = (sel_dvs == '0) ? S_DONE : S_START;
         S_START: state_nx = S_WAIT;
         S_WAIT:  if (cnt == '0) state_nx = S_DONE;
         S_DONE:  if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_dbz       <= 1'b0;
         div_start     <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
         busy          <= 1'b0;
         ptr           <= 2'(NUM_REQ - 1);
         cnt           <= '0;
      end else begin
         div_start <= (state == S_IDLE) && found && (sel_dvs != '0);
         busy      <= (state_nx != S_IDLE);
         case (state)
            S_IDLE: begin
               if (found) begin
                  ptr          <= gidx;
                  rsp_id       <= gidx;
                  div_dividend <= sel_dvd;
                  div_divisor  <= sel_dvs;
                  if (sel_dvs == '0) begin
                     rsp_quotient  <= '1;
                     rsp_remainder <= sel_dvd;
                     rsp_dbz       <= 1'b1;
                     rsp_valid     <= 1'b1;
                  end
               end
            end
            S_START: cnt <= CNT_INIT;
            S_WAIT: begin
               if (cnt == '0) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_dbz       <= 1'b0;
                  rsp_valid     <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
